elevator_fsm: RTL and testbench
===============================

ELEVATOR_FSM -- requirements
Module: elevator_fsm

Interface
REQ-001 SHALL have parameter NUM_FLOORS, default 8, number of served floors (2..8).
REQ-002 SHALL have parameter MOVE_CYCLES, default 4, clock cycles to travel one floor (>=1).
REQ-003 SHALL have parameter DOOR_CYCLES, default 3, clock cycles the door stays open (>=1).
REQ-004 SHALL have port clk  input  1  single system clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port request  input  8  per-floor call pulses or levels, bit i = floor i.
REQ-007 SHALL have port current_floor  output  3  registered car position, binary.
REQ-008 SHALL have port direction  output  1  registered travel preference, 1 = up, 0 = down.
REQ-009 SHALL have port open  output  1  registered door-open indicator.
REQ-010 SHALL have port pending  output  8  registered outstanding-call vector.
REQ-011 SHALL have port moving  output  1  high exactly while in state MOVING.

Function
REQ-012 SHALL OR request into pending every cycle; bits >= NUM_FLOORS are ignored and held 0.
REQ-013 SHALL implement states IDLE, MOVING, DOOR_OPEN; open = (state == DOOR_OPEN).
REQ-014 IDLE: pending[current_floor] set -> DOOR_OPEN; else a call ahead in direction -> MOVING, same direction; else a call behind -> flip direction, MOVING; else stay IDLE.
REQ-015 MOVING SHALL load the timer with MOVE_CYCLES-1 on entry; on expiry current_floor steps +1 (up) or -1 (down) in that same edge.
REQ-016 On arrival, pending[new floor] set -> DOOR_OPEN; else calls remain ahead -> MOVING again (timer reloaded); else -> IDLE.
REQ-017 DOOR_OPEN SHALL clear pending[current_floor] on entry and hold for DOOR_CYCLES cycles, then -> IDLE.
REQ-018 A request for current_floor arriving during DOOR_OPEN SHALL be absorbed (bit not set) and SHALL reload the door timer.
REQ-019 current_floor SHALL never leave 0..NUM_FLOORS-1; at floor 0 no down step, at top floor no up step.
REQ-020 Latency: call for current_floor sampled at edge N in IDLE -> open = 1 after edge N+1.
REQ-021 Simultaneous calls ahead and behind SHALL serve all calls ahead before reversing (SCAN).
REQ-022 A request bit set for a floor already passed in the current sweep SHALL wait until the reverse sweep.

Reset
REQ-023 reset SHALL immediately force state IDLE, current_floor 0, direction 1, open 0, moving 0, pending 0, timer 0, regardless of clock, including mid-move or mid-door.
REQ-024 Requests present while reset is high SHALL be discarded.

Configuration
REQ-025 Macro ELEVATOR_DOOR_HOLD_EN defined: SHALL add input door_hold (1 bit); while high in DOOR_OPEN the door timer is held at DOOR_CYCLES-1 and state stays DOOR_OPEN.
REQ-026 Macro undefined: door_hold port SHALL not exist and door timing is REQ-017/018 only.

Structure
REQ-027 Package elevator_pkg SHALL hold the state enum, MAX_FLOORS = 8, FLOOR_W = 3.
REQ-028 A single sub-module floor_timer (loadable down-counter with expire flag) SHALL serve both move and door timing.
REQ-029 Outputs SHALL connect unmodified to the display stage inputs direction, current_floor, open.

Verification (MOVE_CYCLES 4, DOOR_CYCLES 3)
REQ-030 Reset, pulse request[3] -> floor 0->1->2->3 every 4 cycles, direction 1, then open high 3 cycles, pending[3] cleared.
REQ-031 Idle at 3, direction 1, request[0] and request[5] same cycle -> car reaches 5, opens, reverses, reaches 0, opens.
REQ-032 Idle at 2, pulse request[2] -> open = 1 two edges later, current_floor stays 2, moving stays 0.
REQ-033 Moving up 0->4, pulse request[2] while at floor 1 -> stops and opens at 2, then continues to 4.
REQ-034 reset asserted while moving between floors 2 and 3 -> same-cycle current_floor 0, open 0, pending 0, moving 0.
REQ-035 ELEVATOR_DOOR_HOLD_EN defined, door_hold high 10 cycles during DOOR_OPEN -> open high for 10 + 3 cycles, then IDLE.

Source files
------------

// File: rtl/elevator_pkg.sv
// rtl/elevator_pkg.sv - shared types, sizes and floor-mask helpers for the elevator controller
//
// Purpose : state enum, floor-vector sizing and the mask helpers used to
//           ask "is any call above/below floor f".
// Contents: MAX_FLOORS, FLOOR_W, state_e, above_mask(), below_mask().
package elevator_pkg;

  localparam int MAX_FLOORS = 8;
  localparam int FLOOR_W    = 3;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVING    = 2'd1,
    DOOR_OPEN = 2'd2
  } state_e;

  // Bits strictly above floor f.
  function automatic logic [MAX_FLOORS-1:0] above_mask(input logic [FLOOR_W-1:0] f);
    logic [MAX_FLOORS-1:0] m;
    for (int i = 0; i < MAX_FLOORS; i++) begin
      m[i] = (i > int'(f));
    end
    return m;
  endfunction

  // Bits strictly below floor f.
  function automatic logic [MAX_FLOORS-1:0] below_mask(input logic [FLOOR_W-1:0] f);
    logic [MAX_FLOORS-1:0] m;
    for (int i = 0; i < MAX_FLOORS; i++) begin
      m[i] = (i < int'(f));
    end
    return m;
  endfunction

endpackage

// File: rtl/floor_timer.sv
// rtl/floor_timer.sv - loadable down-counter with expire flag for move and door timing
//
// Purpose : counts down from a loaded value to zero and stops there;
//           expired_o is high while the count is zero.
// Ports   : clk, reset        - clock, asynchronous active-high reset
//           load_i            - load load_value_i this cycle (wins over counting)
//           load_value_i      - value to load
//           expired_o         - count has reached zero
module floor_timer #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_value_i,
  output logic             expired_o
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_value_i;
    end else if (count_q != '0) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign expired_o = (count_q == '0);

endmodule

// File: rtl/elevator_fsm.sv
// rtl/elevator_fsm.sv - single-car SCAN elevator controller
//
// Purpose : collects floor calls into a pending vector and serves them
//           sweep by sweep: every call ahead is served before reversing.
// Ports   : clk, reset        - clock, asynchronous active-high reset
//           request[7:0]      - per-floor call, bit i = floor i
//           door_hold         - (ELEVATOR_DOOR_HOLD_EN only) keeps door open
//           current_floor[2:0]- car position
//           direction         - 1 = up, 0 = down
//           open              - door open (state DOOR_OPEN)
//           pending[7:0]      - outstanding calls
//           moving            - state MOVING
// Config  : define ELEVATOR_DOOR_HOLD_EN to add the door_hold input.
module elevator_fsm
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS  = 8,
  parameter int MOVE_CYCLES = 4,
  parameter int DOOR_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [MAX_FLOORS-1:0] request,
`ifdef ELEVATOR_DOOR_HOLD_EN
  input  logic                  door_hold,
`endif
  output logic [FLOOR_W-1:0]    current_floor,
  output logic                  direction,
  output logic                  open,
  output logic [MAX_FLOORS-1:0] pending,
  output logic                  moving
);

  localparam int MAX_CYC = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
  localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [TW-1:0]         MOVE_LOAD  = TW'(MOVE_CYCLES - 1);
  localparam logic [TW-1:0]         DOOR_LOAD  = TW'(DOOR_CYCLES - 1);
  localparam logic [FLOOR_W-1:0]    TOP_FLOOR  = FLOOR_W'(NUM_FLOORS - 1);
  localparam logic [MAX_FLOORS-1:0] FLOOR_MASK = MAX_FLOORS'((1 << NUM_FLOORS) - 1);

  state_e                  state_q, state_d;
  logic [FLOOR_W-1:0]      floor_q, floor_d;
  logic                    dir_q, dir_d;
  logic [MAX_FLOORS-1:0]   pending_q, pending_d;
  logic                    open_q, moving_q;

  logic                    tmr_load;
  logic [TW-1:0]           tmr_value;
  logic                    tmr_expired;

  logic                    hold;
  logic [MAX_FLOORS-1:0]   req_v;
  logic [FLOOR_W-1:0]      next_floor;
  logic                    ahead_cur, behind_cur, ahead_next, at_limit;

`ifdef ELEVATOR_DOOR_HOLD_EN
  assign hold = door_hold;
`else
  assign hold = 1'b0;
`endif

  floor_timer #(
    .WIDTH (TW)
  ) u_timer (
    .clk          (clk),
    .reset        (reset),
    .load_i       (tmr_load),
    .load_value_i (tmr_value),
    .expired_o    (tmr_expired)
  );

  always_comb begin
    state_d    = state_q;
    floor_d    = floor_q;
    dir_d      = dir_q;
    tmr_load   = 1'b0;
    tmr_value  = '0;
    req_v      = request & FLOOR_MASK;

    // "Ahead" is relative to the current travel preference.
    ahead_cur  = dir_q ? |(pending_q & above_mask(floor_q)) : |(pending_q & below_mask(floor_q));
    behind_cur = dir_q ? |(pending_q & below_mask(floor_q)) : |(pending_q & above_mask(floor_q));
    at_limit   = dir_q ? (floor_q == TOP_FLOOR) : (floor_q == '0);
    next_floor = dir_q ? floor_q + 1'b1 : floor_q - 1'b1;
    ahead_next = dir_q ? |(pending_q & above_mask(next_floor))
                       : |(pending_q & below_mask(next_floor));

    case (state_q)
      IDLE: begin
        if (pending_q[floor_q]) begin
          state_d   = DOOR_OPEN;
          tmr_load  = 1'b1;
          tmr_value = DOOR_LOAD;
        end else if (ahead_cur) begin
          state_d   = MOVING;
          tmr_load  = 1'b1;
          tmr_value = MOVE_LOAD;
        end else if (behind_cur) begin
          dir_d     = ~dir_q;
          state_d   = MOVING;
          tmr_load  = 1'b1;
          tmr_value = MOVE_LOAD;
        end
      end

      MOVING: begin
        if (tmr_expired) begin
          // MOVING is only entered with a call ahead, so at_limit is a guard
          // that keeps the car inside the shaft should that ever not hold.
          if (at_limit) begin
            state_d = IDLE;
          end else begin
            floor_d = next_floor;
            if (pending_q[next_floor]) begin
              state_d   = DOOR_OPEN;
              tmr_load  = 1'b1;
              tmr_value = DOOR_LOAD;
            end else if (ahead_next) begin
              tmr_load  = 1'b1;
              tmr_value = MOVE_LOAD;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end

      DOOR_OPEN: begin
        // A fresh call for this floor (or an explicit hold) restarts the door time.
        if (hold || req_v[floor_q]) begin
          tmr_load  = 1'b1;
          tmr_value = DOOR_LOAD;
        end else if (tmr_expired) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    // Calls accumulate; the floor whose door is (or is about to be) open is
    // cleared, which both serves it on entry and absorbs repeats while open.
    pending_d = pending_q | req_v;
    if (state_d == DOOR_OPEN) begin
      pending_d[floor_d] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      floor_q   <= '0;
      dir_q     <= 1'b1;
      pending_q <= '0;
      open_q    <= 1'b0;
      moving_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      floor_q   <= floor_d;
      dir_q     <= dir_d;
      pending_q <= pending_d;
      open_q    <= (state_d == DOOR_OPEN);
      moving_q  <= (state_d == MOVING);
    end
  end

  assign current_floor = floor_q;
  assign direction     = dir_q;
  assign open          = open_q;
  assign pending       = pending_q;
  assign moving        = moving_q;

endmodule

// File: tb/tb_elevator_fsm.sv
// tb/tb_elevator_fsm.sv - scoreboard bench for elevator_fsm (MOVE_CYCLES 4, DOOR_CYCLES 3)
module tb_elevator_fsm;
  import elevator_pkg::*;

  typedef struct {
    int          cyc;
    logic [13:0] val;  // {floor[2:0], dir, open, moving, pending[7:0]}
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] request;
  logic [2:0] current_floor;
  logic       direction;
  logic       door_open;
  logic [7:0] pending;
  logic       moving;
`ifdef ELEVATOR_DOOR_HOLD_EN
  logic       door_hold;
`endif

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  logic        mon_en = 1'b0;
  logic [13:0] mon_last;

  elevator_fsm #(
    .NUM_FLOORS  (8),
    .MOVE_CYCLES (4),
    .DOOR_CYCLES (3)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .request       (request),
`ifdef ELEVATOR_DOOR_HOLD_EN
    .door_hold     (door_hold),
`endif
    .current_floor (current_floor),
    .direction     (direction),
    .open          (door_open),
    .pending       (pending),
    .moving        (moving)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every change of the visible outputs is one DUT response.
  always @(negedge clk) begin
    logic [13:0] snap;
    exp_t        e;
    if (mon_en) begin
      snap = {current_floor, direction, door_open, moving, pending};
      if (snap != mon_last) begin
        mon_last = snap;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: cyc=%0d floor=%0d dir=%0b open=%0b moving=%0b pending=%02h, required no change",
                   cyc, snap[13:11], snap[10], snap[9], snap[8], snap[7:0]);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || e.val != snap) begin
            errors++;
            $display("FAIL event: got cyc=%0d floor=%0d dir=%0b open=%0b moving=%0b pending=%02h, required cyc=%0d floor=%0d dir=%0b open=%0b moving=%0b pending=%02h",
                     cyc, snap[13:11], snap[10], snap[9], snap[8], snap[7:0],
                     e.cyc, e.val[13:11], e.val[10], e.val[9], e.val[8], e.val[7:0]);
          end
        end
      end
    end
  end

  task automatic ev(input int c0, input int off, input int f, input logic d, input logic o,
                    input logic m, input logic [7:0] p);
    exp_t e;
    e.cyc = c0 + off;
    e.val = {3'(f), d, o, m, p};
    exp_q.push_back(e);
  endtask

  task automatic start(output int c0);
    @(negedge clk);
    c0 = cyc;
  endtask

  task automatic pulse(input logic [7:0] m);
    request = m;
    @(negedge clk);
    request = '0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: %0d events outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, want);
    end
  endtask

  initial begin
    int c0;
    reset   = 1'b1;
    request = 8'h00;
`ifdef ELEVATOR_DOOR_HOLD_EN
    door_hold = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("reset_floor", current_floor, 0);
    chk("reset_dir", direction, 1);
    chk("reset_open", door_open, 0);
    chk("reset_moving", moving, 0);
    chk("reset_pending", pending, 0);
    reset = 1'b0;
    mon_last = {current_floor, direction, door_open, moving, pending};
    mon_en   = 1'b1;
    repeat (2) @(negedge clk);

    // Floor 0 -> 3, door open three cycles.
    start(c0);
    ev(c0, 1, 0, 1, 0, 0, 8'h08);
    ev(c0, 2, 0, 1, 0, 1, 8'h08);
    ev(c0, 6, 1, 1, 0, 1, 8'h08);
    ev(c0, 10, 2, 1, 0, 1, 8'h08);
    ev(c0, 14, 3, 1, 1, 0, 8'h00);
    ev(c0, 17, 3, 1, 0, 0, 8'h00);
    pulse(8'h08);
    drain("up_to_3");

    // Calls at 0 and 5 from floor 3 going up: 5 first, then reverse to 0.
    start(c0);
    ev(c0, 1, 3, 1, 0, 0, 8'h21);
    ev(c0, 2, 3, 1, 0, 1, 8'h21);
    ev(c0, 6, 4, 1, 0, 1, 8'h21);
    ev(c0, 10, 5, 1, 1, 0, 8'h01);
    ev(c0, 13, 5, 1, 0, 0, 8'h01);
    ev(c0, 14, 5, 0, 0, 1, 8'h01);
    ev(c0, 18, 4, 0, 0, 1, 8'h01);
    ev(c0, 22, 3, 0, 0, 1, 8'h01);
    ev(c0, 26, 2, 0, 0, 1, 8'h01);
    ev(c0, 30, 1, 0, 0, 1, 8'h01);
    ev(c0, 34, 0, 0, 1, 0, 8'h00);
    ev(c0, 37, 0, 0, 0, 0, 8'h00);
    pulse(8'h21);
    drain("scan_5_then_0");

    // From floor 0 heading down: call behind flips direction, go to 2.
    start(c0);
    ev(c0, 1, 0, 0, 0, 0, 8'h04);
    ev(c0, 2, 0, 1, 0, 1, 8'h04);
    ev(c0, 6, 1, 1, 0, 1, 8'h04);
    ev(c0, 10, 2, 1, 1, 0, 8'h00);
    ev(c0, 13, 2, 1, 0, 0, 8'h00);
    pulse(8'h04);
    drain("flip_to_2");

    // Call at current floor: open two edges later; repeat call absorbed, door reloads.
    start(c0);
    ev(c0, 1, 2, 1, 0, 0, 8'h04);
    ev(c0, 2, 2, 1, 1, 0, 8'h00);
    ev(c0, 7, 2, 1, 0, 0, 8'h00);
    pulse(8'h04);
    repeat (2) @(negedge clk);
    pulse(8'h04);
    drain("same_floor_absorb");

    // Reset mid-move between 2 and 3, with a request held during reset.
    start(c0);
    ev(c0, 1, 2, 1, 0, 0, 8'h20);
    ev(c0, 2, 2, 1, 0, 1, 8'h20);
    pulse(8'h20);
    repeat (2) @(negedge clk);
    ev(c0, 4, 0, 1, 0, 0, 8'h00);
    #2;
    reset   = 1'b1;
    request = 8'h10;
    #1;
    chk("midmove_reset_floor", current_floor, 0);
    chk("midmove_reset_open", door_open, 0);
    chk("midmove_reset_pending", pending, 0);
    chk("midmove_reset_moving", moving, 0);
    chk("midmove_reset_dir", direction, 1);
    repeat (2) @(negedge clk);
    request = 8'h00;
    #1;
    reset = 1'b0;
    drain("midmove_reset");
    chk("reset_discards_request", pending, 0);

    // Going 0 -> 4, call at 2 added while at floor 1: stop at 2 then continue.
    start(c0);
    ev(c0, 1, 0, 1, 0, 0, 8'h10);
    ev(c0, 2, 0, 1, 0, 1, 8'h10);
    ev(c0, 6, 1, 1, 0, 1, 8'h10);
    ev(c0, 8, 1, 1, 0, 1, 8'h14);
    ev(c0, 10, 2, 1, 1, 0, 8'h10);
    ev(c0, 13, 2, 1, 0, 0, 8'h10);
    ev(c0, 14, 2, 1, 0, 1, 8'h10);
    ev(c0, 18, 3, 1, 0, 1, 8'h10);
    ev(c0, 22, 4, 1, 1, 0, 8'h00);
    ev(c0, 25, 4, 1, 0, 0, 8'h00);
    pulse(8'h10);
    repeat (6) @(negedge clk);
    pulse(8'h04);
    drain("stop_on_way");

    // To the top floor; a call for an already-passed floor waits for the down sweep.
    start(c0);
    ev(c0, 1, 4, 1, 0, 0, 8'h80);
    ev(c0, 2, 4, 1, 0, 1, 8'h80);
    ev(c0, 6, 5, 1, 0, 1, 8'h80);
    ev(c0, 8, 5, 1, 0, 1, 8'h90);
    ev(c0, 10, 6, 1, 0, 1, 8'h90);
    ev(c0, 14, 7, 1, 1, 0, 8'h10);
    ev(c0, 17, 7, 1, 0, 0, 8'h10);
    ev(c0, 18, 7, 0, 0, 1, 8'h10);
    ev(c0, 22, 6, 0, 0, 1, 8'h10);
    ev(c0, 26, 5, 0, 0, 1, 8'h10);
    ev(c0, 30, 4, 0, 1, 0, 8'h00);
    ev(c0, 33, 4, 0, 0, 0, 8'h00);
    pulse(8'h80);
    repeat (6) @(negedge clk);
    pulse(8'h10);
    drain("top_and_passed");

`ifdef ELEVATOR_DOOR_HOLD_EN
    // door_hold high for 10 cycles keeps the door open 10 + 3 cycles.
    start(c0);
    ev(c0, 1, 4, 0, 0, 0, 8'h10);
    ev(c0, 2, 4, 0, 1, 0, 8'h00);
    ev(c0, 15, 4, 0, 0, 0, 8'h00);
    pulse(8'h10);
    @(negedge clk);
    door_hold = 1'b1;
    repeat (10) @(negedge clk);
    door_hold = 1'b0;
    drain("door_hold");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
